// File: rtl/maverickOne_pkg.sv
// rtl/maverickOne_pkg.sv - shared core types, including the external write-back arbiter request.
package maverickOne_pkg;

  localparam int XLEN            = 64;
  localparam int NUM_REGS        = 64;
  localparam int REG_AW          = $clog2(NUM_REGS);
  localparam int NUM_EXT_ARB_REQ = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   result;
    logic              word;
  } ext_arb_req_t;

  // Word results are sign-extended from bit 31 to the full register width.
  function automatic logic [XLEN-1:0] wb_format(input logic [XLEN-1:0] result, input logic word);
    if (word) return {{(XLEN-32){result[31]}}, result[31:0]};
    return result;
  endfunction

endpackage

// File: rtl/ext_arb_rr_pick.sv
// rtl/ext_arb_rr_pick.sv - combinational rotate-priority picker starting at ptr.
module ext_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PW-1:0]      ptr_i,
  output logic               any_o,
  output logic [PW-1:0]      g_o
);

  logic [2*NUM_REQ-1:0] w_dbl;
  int                   w_hit;

  assign w_dbl = {valid_i, valid_i};

  // Scan the window [ptr, ptr+NUM_REQ) of the doubled vector; descending so the lowest hit wins.
  always_comb begin
    any_o = 1'b0;
    w_hit = 0;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (w_dbl[j] && (j >= int'(ptr_i)) && (j < int'(ptr_i) + NUM_REQ)) begin
        w_hit = j;
        any_o = 1'b1;
      end
    end
    g_o = (w_hit >= NUM_REQ) ? PW'(w_hit - NUM_REQ) : PW'(w_hit);
  end

endmodule

// File: rtl/ext_arb_ctrl.sv
// rtl/ext_arb_ctrl.sv - round-robin arbiter for the shared register-file write port.
module ext_arb_ctrl
  import maverickOne_pkg::*;
#(
  parameter int NUM_REQ = NUM_EXT_ARB_REQ,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  ext_arb_req_t       req_i [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic [REG_AW-1:0]  wb_rd_o,
  output logic [XLEN-1:0]    wb_data_o,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [PW-1:0]      grant_idx_o
);

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_grant;
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_any;
  logic [PW-1:0]     w_g;
  logic              w_stage_free;
  logic              w_accept;
  ext_arb_req_t      w_win;
  logic [PW-1:0]     w_ptr_next;

  ext_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (r_ptr),
    .any_o   (w_any),
    .g_o     (w_g)
  );

  assign w_stage_free = !r_wb_valid || wb_ready_i;
  assign w_accept     = !rst_i && w_any && w_stage_free;
  assign w_win        = req_i[w_g];
  assign w_ptr_next   = (w_g == PW'(NUM_REQ-1)) ? '0 : w_g + PW'(1);

  always_comb begin
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_g] = 1'b1;
  end

  // A drained stage refills in the same cycle; x0 writes handshake but never load the stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_ptr_next;
      r_grant <= w_g;
      if (w_win.rd != '0) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= w_win.rd;
        r_wb_data  <= wb_format(w_win.result, w_win.word);
      end else begin
        r_wb_valid <= 1'b0;
      end
    end else if (wb_ready_i) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign wb_valid_o  = r_wb_valid;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign grant_idx_o = r_grant;

endmodule

// File: doc/ext_arb_ctrl.md
# ext_arb_ctrl

Round-robin write-back arbiter that shares the single external register-file write port among `NUM_REQ` execution units, each presenting an `ext_arb_req_t` under a valid/ready handshake. It owns a one-entry output stage and applies word-result sign-extension. It discards writes to x0. It sits between the execution units (ALU, MUL/DIV, FPU, LSU, CSR) and the GPR/FPR write port.

## Interface

- `NUM_REQ`, default 4: number of requesters. Legal range is 2..16.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_i`, in, `NUM_REQ` × `ext_arb_req_t`: per-requester payload (`rd`, `result`, `word`).
- `req_valid_i`, in, `NUM_REQ`: per-requester valid.
- `req_ready_o`, out, `NUM_REQ`: per-requester ready. At most one bit is high per cycle.
- `wb_rd_o`, out, `$clog2(NUM_REGS)`: destination register, 0..63. Values 32..63 are FPRs.
- `wb_data_o`, out, `XLEN`: write data.
- `wb_valid_o`, out, 1: the output stage holds a write.
- `wb_ready_i`, in, 1: the register file accepts the write.
- `grant_idx_o`, out, `$clog2(NUM_REQ)`: index of the last accepted requester, for debug and performance counters.

## Operation

- **Round-robin pointer.** `ptr` has `$clog2(NUM_REQ)` bits. Search starts at `ptr` and wraps modulo `NUM_REQ`. The first valid requester found is the winner `g`.
- **Stage free condition.** `stage_free = !wb_valid_o || wb_ready_i`.
- **Ready.**
  - `req_ready_o[g] = stage_free` when any valid exists.
  - All other ready bits are 0.
  - Ready may depend combinationally on valid. Requesters must never gate valid on ready.
  - Once asserted, valid must remain asserted with a stable payload until accepted.
- **Accept.** Requester `g` is accepted when `req_valid_i[g] && req_ready_o[g]`. On accept:
  - `ptr` becomes `(g+1) mod NUM_REQ`.
  - `grant_idx_o` becomes `g`.
- **Data formatting.**
  - `word=1`: `wb_data_o = {{32{result[31]}}, result[31:0]}`.
  - `word=0`: `result` passes unchanged.
  - `rd` passes unchanged.
- **x0 writes.** An accepted request with `rd==0` completes its handshake and advances `ptr`. `wb_valid_o` is not set by it. `rd==32` (f0) is a real register and is forwarded.
- **Output stage.**
  - Accept with `rd!=0`: the stage loads and `wb_valid_o` is 1 next cycle.
  - No accept (or x0 accept) while `wb_ready_i` is 1: `wb_valid_o` goes to 0.
  - `wb_valid_o && !wb_ready_i`: `wb_rd_o` and `wb_data_o` hold stable.
- **No requests.** `ptr` is unchanged when there is no accept.
- **Reset mid-operation.** The held write is dropped. There is no replay.

## Timing

- Reset values of registered outputs: `wb_valid_o`=0, `wb_rd_o`=0, `wb_data_o`=0, `grant_idx_o`=0, `ptr`=0.
- During reset, `req_ready_o` is all-0 regardless of `req_valid_i`.
- Latency is 1 cycle: accept at edge N drives `wb_valid_o` in cycle N+1.
- Throughput is 1 write per cycle under continuous `wb_ready_i=1`. Drain and refill happen in the same cycle.
- Backpressure: while `wb_valid_o=1` and `wb_ready_i=0`, every `req_ready_o` is 0.
- Fairness: with all requesters continuously valid and `wb_ready_i=1`, each requester is granted exactly once every `NUM_REQ` cycles.

## Structure

- `maverickOne_pkg` gains `NUM_EXT_ARB_REQ` (default 4). The existing `ext_arb_req_t` is reused unchanged.
- Sub-module `ext_arb_rr_pick`: a combinational rotate-priority picker.
  - Inputs: `valid[NUM_REQ]`, `ptr`.
  - Outputs: `any`, `g`.
  - Implemented as a double-width valid vector, a priority encode, and a modulo correction.
- The top level holds `ptr`, the output stage, the formatting logic and the handshake logic.

## Test plan

- **Reset:** hold `rst_i` 2 cycles with all valids high. Require all outputs 0, `req_ready_o`=0, and first grant to requester 0 in the first cycle after release.
- **Round-robin:** all 4 valid, `wb_ready_i`=1, distinct `rd` 1..4. Require grant order 0,1,2,3,0 and `wb_rd_o` sequence 1,2,3,4,1, one per cycle.
- **Word sign-extension:**
  - `result=0x0000_0000_8000_0001`, `word=1` → `wb_data_o=0xFFFF_FFFF_8000_0001`.
  - Same `result` with `word=0` → passes unchanged.
- **Backpressure:** requester 2 writes `rd=5`, then `wb_ready_i`=0 for 3 cycles. Require:
  - Output stable and `req_ready_o`=0 throughout.
  - On release, the next winner is accepted in the same cycle the stage drains.
- **x0 drop:** requester 1 sends `rd=0` then `rd=33`. Require:
  - The first handshake completes and `ptr` advances, with `wb_valid_o`=0.
  - `wb_rd_o=33` is seen next.
- **Reset mid-stall:** `wb_valid_o`=1, `wb_ready_i`=0, assert `rst_i`. Require `wb_valid_o`=0 the next cycle and the held write never appears.
